// File: rtl/mips_cpu_pkg.sv
// Shared types for the CPU's multiply/divide unit: operation encodings and FSM states.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mips_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH-1:0] new_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, next_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign new_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO. Works on operand magnitudes and
// applies the sign correction in FIN, so HI/LO only ever change on the FIN exit edge.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit MUL_ITERATIVE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t state, state_next;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   opd_q;
    logic [2*WIDTH-1:0] work;
    logic               neg_q;
    logic               neg_r;
    logic               dbz;
    logic [CW-1:0]      count;

    logic               accept;
    logic               op_is_mul;
    logic               op_is_div;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_iter;
    logic [2*WIDTH-1:0] mul_full;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;

    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;

    assign op_ready  = (state == ST_IDLE);
    assign busy      = !op_ready;
    assign accept    = op_valid && op_ready && !flush;

    assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = op_signed && a[WIDTH-1];
    assign b_neg     = op_signed && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign last_iter = (count == CW'(WIDTH - 1));

    // Shift-add multiply: lower half starts as the multiplier and drains out as the product fills in.
    assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? opd_q : {WIDTH{1'b0}})};
    assign mul_iter = {mul_sum, work[WIDTH-1:1]};
    assign mul_full = {{WIDTH{1'b0}}, opd_q} * {{WIDTH{1'b0}}, work[WIDTH-1:0]};

    mips_cpu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (work[2*WIDTH-1:WIDTH]),
        .divisor  (opd_q),
        .next_bit (work[WIDTH-1]),
        .new_rem  (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op_is_mul)                          state_next = ST_MUL;
                    else if (op_is_div && (b != '0))        state_next = ST_DIV;
                    else                                    state_next = ST_FIN;
                end
            end
            ST_MUL:  if (!MUL_ITERATIVE || last_iter) state_next = ST_FIN;
            ST_DIV:  if (last_iter) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush && (state != ST_IDLE)) state_next = ST_IDLE;
    end

    // Sign fix-up and HI/LO selection, committed only on the FIN exit edge.
    always_comb begin
        mul_res = neg_q ? -work : work;
        quo_fix = neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        rem_fix = neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
        hi_next = hi;
        lo_next = lo;
        case (op_q)
            OP_MULT, OP_MULTU: {hi_next, lo_next} = mul_res;
            OP_DIV, OP_DIVU: begin
                if (dbz) begin
                    hi_next = a_q;
                    lo_next = {WIDTH{1'b1}};
                end else begin
                    hi_next = rem_fix;
                    lo_next = quo_fix;
                end
            end
            OP_MTHI: hi_next = a_q;
            OP_MTLO: lo_next = a_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            a_q   <= '0;
            opd_q <= '0;
            work  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz   <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        a_q   <= a;
                        opd_q <= op_is_mul ? a_mag : b_mag;
                        work  <= {{WIDTH{1'b0}}, (op_is_mul ? b_mag : a_mag)};
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dbz   <= (b == '0);
                        count <= '0;
                    end
                end
                ST_MUL: begin
                    work  <= MUL_ITERATIVE ? mul_iter : mul_full;
                    count <= count + 1'b1;
                end
                ST_DIV: begin
                    work  <= {step_rem, work[WIDTH-2:0], step_q};
                    count <= count + 1'b1;
                end
                ST_FIN: begin
                    if (!flush) begin
                        hi   <= hi_next;
                        lo   <= lo_next;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: a 32-bit iterative instance and a 16-bit
// single-cycle-multiply instance, with hand-computed results and latencies.
module tb_mips_cpu_muldiv;

    logic        clk;
    logic        reset;

    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        v2;
    logic        ready2;
    logic [2:0]  op2;
    logic [15:0] a2;
    logic [15:0] b2;
    logic        flush2;
    logic        busy2;
    logic        done2;
    logic [15:0] hi2;
    logic [15:0] lo2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    mips_cpu_muldiv #(.WIDTH(32), .MUL_ITERATIVE(1'b1)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    mips_cpu_muldiv #(.WIDTH(16), .MUL_ITERATIVE(1'b0)) dut16 (
        .clk(clk), .reset(reset), .op_valid(v2), .op_ready(ready2),
        .op(op2), .a(a2), .b(b2), .flush(flush2), .busy(busy2), .done(done2),
        .hi(hi2), .lo(lo2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one edge; returns #1 after the accept edge.
    task automatic start_op(input bit which, input logic [2:0] o,
                            input logic [31:0] x, input logic [31:0] y);
        if (!which) begin
            op_valid = 1'b1; op = o; a = x; b = y;
        end else begin
            v2 = 1'b1; op2 = o; a2 = x[15:0]; b2 = y[15:0];
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        v2 = 1'b0;
    endtask

    // Cycles counted with the first post-accept cycle as 1; capped at 100.
    task automatic wait_done(input bit which, output int cycles);
        cycles = 1;
        while (!(which ? done2 : done) && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready: got %b want 1", op_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        start_op(0, 3'd0, 32'hFFFF_FFFE, 32'd3);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL mult_busy: got %b want 1", busy); end
        wait_done(0, cyc);
        n_cmp++; if (cyc != 34) begin n_err++; $display("[TB] FAIL mult_latency: got %0d want 34", cyc); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL mult_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("[TB] FAIL mult_lo: got %h want fffffffa", lo); end
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("[TB] FAIL mult_ready_at_done: got %b want 1", op_ready); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL mult_done_pulse: got %b want 0", done); end

        start_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, cyc);
        n_cmp++; if (cyc != 34) begin n_err++; $display("[TB] FAIL multu_latency: got %0d want 34", cyc); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL multu_hi: got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("[TB] FAIL multu_lo: got %h want 00000001", lo); end
    endtask

    task automatic test_div();
        start_op(0, 3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, cyc);
        n_cmp++; if (cyc != 34) begin n_err++; $display("[TB] FAIL div_latency: got %0d want 34", cyc); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("[TB] FAIL div_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL div_hi: got %h want ffffffff", hi); end

        start_op(0, 3'd3, 32'd100, 32'd7);
        wait_done(0, cyc);
        n_cmp++; if (lo !== 32'd14) begin n_err++; $display("[TB] FAIL divu_lo: got %h want 0000000e", lo); end
        n_cmp++; if (hi !== 32'd2) begin n_err++; $display("[TB] FAIL divu_hi: got %h want 00000002", hi); end

        start_op(0, 3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done(0, cyc);
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("[TB] FAIL div_negdivisor_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'd1) begin n_err++; $display("[TB] FAIL div_negdivisor_hi: got %h want 00000001", hi); end

        start_op(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, cyc);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("[TB] FAIL div_overflow_lo: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("[TB] FAIL div_overflow_hi: got %h want 0", hi); end
    endtask

    task automatic test_back_to_back();
        start_op(0, 3'd3, 32'h0000_1234, 32'd0);
        wait_done(0, cyc);
        n_cmp++; if (cyc != 2) begin n_err++; $display("[TB] FAIL dbz_latency: got %0d want 2", cyc); end
        n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("[TB] FAIL dbz_hi: got %h want 00001234", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL dbz_lo: got %h want ffffffff", lo); end
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_ready: got %b want 1", op_ready); end

        start_op(0, 3'd5, 32'd5, 32'd0);
        wait_done(0, cyc);
        n_cmp++; if (cyc != 2) begin n_err++; $display("[TB] FAIL mtlo_latency: got %0d want 2", cyc); end
        n_cmp++; if (lo !== 32'd5) begin n_err++; $display("[TB] FAIL mtlo_lo: got %h want 00000005", lo); end
        n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("[TB] FAIL mtlo_hi: got %h want 00001234", hi); end

        start_op(0, 3'd4, 32'h0000_ABCD, 32'd9);
        wait_done(0, cyc);
        n_cmp++; if (hi !== 32'h0000_ABCD) begin n_err++; $display("[TB] FAIL mthi_hi: got %h want 0000abcd", hi); end
        n_cmp++; if (lo !== 32'd5) begin n_err++; $display("[TB] FAIL mthi_lo: got %h want 00000005", lo); end

        start_op(0, 3'd7, 32'h1111_1111, 32'h2222_2222);
        wait_done(0, cyc);
        n_cmp++; if (cyc != 2) begin n_err++; $display("[TB] FAIL badop_latency: got %0d want 2", cyc); end
        n_cmp++; if (hi !== 32'h0000_ABCD) begin n_err++; $display("[TB] FAIL badop_hi: got %h want 0000abcd", hi); end
        n_cmp++; if (lo !== 32'd5) begin n_err++; $display("[TB] FAIL badop_lo: got %h want 00000005", lo); end
    endtask

    task automatic test_flush();
        int seen;
        start_op(0, 3'd3, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_ready: got %b want 1", op_ready); end
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("[TB] FAIL flush_no_done: got %0d pulses want 0", seen); end
        n_cmp++; if (hi !== 32'h0000_ABCD) begin n_err++; $display("[TB] FAIL flush_hi: got %h want 0000abcd", hi); end
        n_cmp++; if (lo !== 32'd5) begin n_err++; $display("[TB] FAIL flush_lo: got %h want 00000005", lo); end

        op_valid = 1'b1; op = 3'd4; a = 32'hDEAD_0000; b = 32'd0; flush = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0;
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_idle_reject: got ready %b want 1", op_ready); end
        seen = 0;
        repeat (4) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("[TB] FAIL flush_idle_no_done: got %0d pulses want 0", seen); end
        n_cmp++; if (hi !== 32'h0000_ABCD) begin n_err++; $display("[TB] FAIL flush_idle_hi: got %h want 0000abcd", hi); end
    endtask

    task automatic test_reset_mid();
        start_op(0, 3'd0, 32'd12345, 32'd678);
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("[TB] FAIL midreset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("[TB] FAIL midreset_lo: got %h want 0", lo); end
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("[TB] FAIL midreset_ready: got %b want 1", op_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_nonitr();
        start_op(1, 3'd0, 32'h8000, 32'h8000);
        wait_done(1, cyc);
        n_cmp++; if (cyc != 3) begin n_err++; $display("[TB] FAIL w16_mult_latency: got %0d want 3", cyc); end
        n_cmp++; if (hi2 !== 16'h4000) begin n_err++; $display("[TB] FAIL w16_mult_hi: got %h want 4000", hi2); end
        n_cmp++; if (lo2 !== 16'h0000) begin n_err++; $display("[TB] FAIL w16_mult_lo: got %h want 0000", lo2); end

        start_op(1, 3'd1, 32'hFFFF, 32'hFFFF);
        wait_done(1, cyc);
        n_cmp++; if (hi2 !== 16'hFFFE) begin n_err++; $display("[TB] FAIL w16_multu_hi: got %h want fffe", hi2); end
        n_cmp++; if (lo2 !== 16'h0001) begin n_err++; $display("[TB] FAIL w16_multu_lo: got %h want 0001", lo2); end

        start_op(1, 3'd2, 32'hFF9C, 32'd7);
        wait_done(1, cyc);
        n_cmp++; if (cyc != 18) begin n_err++; $display("[TB] FAIL w16_div_latency: got %0d want 18", cyc); end
        n_cmp++; if (lo2 !== 16'hFFF2) begin n_err++; $display("[TB] FAIL w16_div_lo: got %h want fff2", lo2); end
        n_cmp++; if (hi2 !== 16'hFFFE) begin n_err++; $display("[TB] FAIL w16_div_hi: got %h want fffe", hi2); end
    endtask

    initial begin
        op_valid = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
        v2 = 1'b0; op2 = 3'd0; a2 = '0; b2 = '0; flush2 = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_nonitr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
